// File: rtl/gray_counter_updown.sv
// gray_counter_updown: WIDTH-bit up/down counter that presents registered
// binary and Gray views of the same count, with synchronous parallel load
// and a one-cycle wrap pulse.
//
// Optional build macro GRAY_CNT_SATURATE_EN: the counter saturates at
// 2^WIDTH-1 (up) and 0 (down) instead of wrapping. wrap then pulses for
// the cycle after every enabled edge whose step was suppressed.
//
// Interface timing: there is no valid/ready handshake. The outputs are
// plain registers that are valid every cycle after reset. A sampled en or
// load is reflected on the outputs one cycle later.
//
// Priority at each rising edge: rst > load > en. The count state is the
// binary register alone. gray_count is derived from the next binary value
// and registered on the same edge, so the two views always agree.
module gray_counter_updown #(
  parameter int          WIDTH   = 4,
  parameter logic [31:0] RST_VAL = 32'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_count,
  output logic [WIDTH-1:0] bin_count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RST_BIN = RST_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap_q;

  logic [WIDTH-1:0] bin_step;
  logic [WIDTH-1:0] bin_next;
  logic             at_bound;
  logic             wrap_next;

  // Candidate step and wrap/saturation boundary for the sampled direction.
  always_comb begin
    bin_step = up_dn ? (bin_q + ONE) : (bin_q - ONE);
    at_bound = up_dn ? (bin_q == MAX_VAL) : (bin_q == ZERO);
  end

  // Next binary value and wrap pulse, applying load over enable.
  always_comb begin
    bin_next  = bin_q;
    wrap_next = 1'b0;
    if (load) begin
      // A load never raises wrap, even with en high in the same cycle.
      bin_next = load_val;
    end else if (en) begin
      wrap_next = at_bound;
`ifdef GRAY_CNT_SATURATE_EN
      // Suppress the step at the bound; wrap then flags the saturation.
      if (!at_bound) begin
        bin_next = bin_step;
      end
`else
      bin_next = bin_step;
`endif
    end
  end

  // Count registers; reset overrides load and enable and clears wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= RST_BIN;
      gray_q <= to_gray(RST_BIN);
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_next;
      gray_q <= to_gray(bin_next);
      wrap_q <= wrap_next;
    end
  end

  assign bin_count  = bin_q;
  assign gray_count = gray_q;
  assign wrap       = wrap_q;

endmodule
